// File: rtl/tu_bitslip_ctrl_pkg.sv
// Shared definitions for the trigger-unit link alignment sequencer.
//   - DATA_W / TRAIN_PAT_DEF : deserialised word width and default training word
//   - tu_state_e             : sequencer state encoding, also exported for debug
//   - STAT_*                 : bit positions of the link-status word read by the
//                              AXI register bank, plus a helper that packs it
package tu_bitslip_ctrl_pkg;

    localparam int DATA_W = 64;
    localparam logic [DATA_W-1:0] TRAIN_PAT_DEF = 64'hBC50_BC50_BC50_BC50;

    // slip_count port width; MAX_SLIPS must fit in it
    localparam int SLIP_CNT_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } tu_state_e;

    // link-status word layout
    localparam int STATUS_W          = 16;
    localparam int STAT_LOCKED_BIT   = 0;
    localparam int STAT_FAIL_BIT     = 1;
    localparam int STAT_FIFO_ENA_BIT = 2;
    localparam int STAT_SLIP_LSB     = 8;

    function automatic logic [STATUS_W-1:0] pack_status(
        input logic                  locked,
        input logic                  fail,
        input logic                  fifo_ena,
        input logic [SLIP_CNT_W-1:0] slips
    );
        logic [STATUS_W-1:0] s;
        s = '0;
        s[STAT_LOCKED_BIT]                 = locked;
        s[STAT_FAIL_BIT]                   = fail;
        s[STAT_FIFO_ENA_BIT]               = fifo_ena;
        s[STAT_SLIP_LSB +: SLIP_CNT_W]     = slips;
        return s;
    endfunction

endpackage

// File: rtl/tu_bitslip_ctrl_if.sv
// Link-side bundle of the alignment sequencer.
//   master : the link / register-bank side (drives start, train_mode, raw_data)
//   slave  : the sequencer (drives bitslip, fifo_ena, locked, fail, slip_count,
//            link_status and the state_dbg observation port)
// Signalling: there is no valid/ready pair on this link. raw_data is taken as a
// new word on every clock edge; start is a single-cycle request that is acted on
// at the edge where it is sampled high, with no acknowledge; bitslip is a
// single-cycle pulse to the ISERDES with no acknowledge.
interface tu_bitslip_ctrl_if;
    import tu_bitslip_ctrl_pkg::*;

    logic                  start;
    logic                  train_mode;
    logic [DATA_W-1:0]     raw_data;
    logic                  bitslip;
    logic                  fifo_ena;
    logic                  locked;
    logic                  fail;
    logic [SLIP_CNT_W-1:0] slip_count;
    logic [STATUS_W-1:0]   link_status;
    tu_state_e             state_dbg;

    modport master (
        output start, train_mode, raw_data,
        input  bitslip, fifo_ena, locked, fail, slip_count, link_status, state_dbg
    );

    modport slave (
        input  start, train_mode, raw_data,
        output bitslip, fifo_ena, locked, fail, slip_count, link_status, state_dbg
    );

endinterface

// File: rtl/tu_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : clear to zero
//   inc_i     : increment by one, holding at MAX
//   count_o   : current count, $clog2(MAX+1) bits wide
module tu_sat_counter #(
    parameter  int MAX = 15,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tu_bitslip_ctrl.sv
// Word-alignment sequencer for the trigger-unit 64-bit deserialised link.
// Compares each raw word with the training pattern, pulses the ISERDES bitslip
// until LOCK_CNT consecutive matches are seen, and only then enables the TU
// capture FIFO. All outputs are registered from the next-state decision, so they
// change on the same edge the state register does.
//   S_AXI_ACLK   : system clock
//   S_AXI_ARESET : asynchronous active-high reset
//   link         : slave side of tu_bitslip_ctrl_if (start, train_mode, raw_data
//                  in; bitslip, fifo_ena, locked, fail, slip_count, link_status,
//                  state_dbg out)
module tu_bitslip_ctrl
    import tu_bitslip_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] TRAIN_PAT = TRAIN_PAT_DEF,
    parameter int                SLIP_WAIT = 4,
    parameter int                MAX_SLIPS = 64,
    parameter int                LOCK_CNT  = 16,
    parameter int                ERR_LIMIT = 4
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    tu_bitslip_ctrl_if.slave  link
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int SW = $clog2(MAX_SLIPS + 1);

    localparam logic [MW-1:0] MATCH_LAST_V = MW'(LOCK_CNT - 1);
    localparam logic [EW-1:0] ERR_LAST_V   = EW'(ERR_LIMIT - 1);
    localparam logic [WW-1:0] WAIT_LAST_V  = WW'(SLIP_WAIT - 1);
    localparam logic [SW-1:0] SLIP_MAX_V   = SW'(MAX_SLIPS);

    if (MAX_SLIPS > 127) begin : g_max_slips_chk
        $error("tu_bitslip_ctrl: MAX_SLIPS must be <= 127");
    end

    tu_state_e state_q, state_d;
    logic      bitslip_q, fifo_ena_q, locked_q, fail_q;

    logic          match;
    logic          match_clr, match_inc;
    logic          err_clr, err_inc;
    logic          wait_clr, wait_inc;
    logic          slip_clr, slip_inc;
    logic [MW-1:0] match_cnt;
    logic [EW-1:0] err_cnt;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] slip_cnt;

    assign match = (link.raw_data == TRAIN_PAT);

    // Counter controls. A start request clears every counter regardless of
    // state; otherwise each counter only runs in the state that owns it and is
    // held at zero elsewhere (slip count is the exception: it survives a relock).
    always_comb begin
        match_clr = 1'b1;
        match_inc = 1'b0;
        err_clr   = 1'b1;
        err_inc   = 1'b0;
        wait_clr  = 1'b1;
        wait_inc  = 1'b0;
        slip_clr  = link.start;
        slip_inc  = 1'b0;
        if (!link.start) begin
            case (state_q)
                ST_CHECK: begin
                    match_clr = !match;
                    match_inc = match;
                    slip_inc  = !match && (slip_cnt != SLIP_MAX_V);
                end
                ST_WAIT: begin
                    wait_clr = 1'b0;
                    wait_inc = 1'b1;
                end
                ST_LOCKED: begin
                    // with train_mode low the link carries payload: hold the count
                    err_clr = link.train_mode && match;
                    err_inc = link.train_mode && !match;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (link.start) begin
            state_d = ST_CHECK;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_CHECK: begin
                    if (match) begin
                        if (match_cnt == MATCH_LAST_V) state_d = ST_LOCKED;
                    end else if (slip_cnt == SLIP_MAX_V) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
                ST_SLIP:  state_d = ST_WAIT;
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST_V) state_d = ST_CHECK;
                end
                ST_LOCKED: begin
                    if (link.train_mode && !match && (err_cnt == ERR_LAST_V)) state_d = ST_CHECK;
                end
                ST_FAIL: ;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q    <= ST_IDLE;
            bitslip_q  <= 1'b0;
            fifo_ena_q <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitslip_q  <= (state_d == ST_SLIP);
            // fifo_ena and locked come from the same decode so they always move together
            fifo_ena_q <= (state_d == ST_LOCKED);
            locked_q   <= (state_d == ST_LOCKED);
            fail_q     <= (state_d == ST_FAIL);
        end
    end

    tu_sat_counter #(.MAX(LOCK_CNT)) u_match_cnt (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .clr_i(match_clr), .inc_i(match_inc), .count_o(match_cnt)
    );

    tu_sat_counter #(.MAX(ERR_LIMIT)) u_err_cnt (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .clr_i(err_clr), .inc_i(err_inc), .count_o(err_cnt)
    );

    tu_sat_counter #(.MAX(SLIP_WAIT)) u_wait_cnt (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .clr_i(wait_clr), .inc_i(wait_inc), .count_o(wait_cnt)
    );

    tu_sat_counter #(.MAX(MAX_SLIPS)) u_slip_cnt (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .clr_i(slip_clr), .inc_i(slip_inc), .count_o(slip_cnt)
    );

    assign link.bitslip     = bitslip_q;
    assign link.fifo_ena    = fifo_ena_q;
    assign link.locked      = locked_q;
    assign link.fail        = fail_q;
    assign link.slip_count  = SLIP_CNT_W'(slip_cnt);
    assign link.link_status = pack_status(locked_q, fail_q, fifo_ena_q, SLIP_CNT_W'(slip_cnt));
    assign link.state_dbg   = state_q;

endmodule

// File: tb/tb_tu_bitslip_ctrl.sv
`timescale 1ns/1ps
module tb_tu_bitslip_ctrl;
  import tu_bitslip_ctrl_pkg::*;

  localparam int W           = 32;
  localparam int SLIP_WAIT   = 4;
  localparam int MAX_SLIPS   = 64;
  localparam int LOCK_CNT    = 16;
  localparam int ERR_LIMIT   = 4;
  localparam int SLIP_PERIOD = SLIP_WAIT + 2;
  localparam int PAT_PERIOD  = 16;  // BC50 repeats every 16 bits
  localparam logic [63:0] PAT = 64'hBC50_BC50_BC50_BC50;

  localparam int DM_LINK = 0;  // aligned-by-bitslip link model
  localparam int DM_RAND = 1;  // random non-pattern words
  localparam int DM_OVR  = 2;  // word supplied by the test

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tu_bitslip_ctrl_if link();

  tu_bitslip_ctrl #(
    .TRAIN_PAT(PAT), .SLIP_WAIT(SLIP_WAIT), .MAX_SLIPS(MAX_SLIPS),
    .LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .link(link)
  );

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;
  int e0    = 0;           // cycle index of the edge that sampled start
  int phase = 0;           // link model: bit rotation of the incoming word
  int data_mode = DM_LINK;
  int n_pulses  = 0;
  int last_pulse = -1000;
  logic [63:0] ovr_word = '0;
  logic [W-1:0] exp_q[$];  // relative cycles at which bitslip is expected

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int rel();
    return cyc - e0;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] w, input int n);
    int k;
    k = n % 64;
    if (k == 0) return w;
    return (w << k) | (w >> (64 - k));
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w == PAT) w = ~w;
    return w;
  endfunction

  function automatic logic [63:0] link_word();
    case (data_mode)
      DM_LINK: return rotl(PAT, phase);
      DM_RAND: return rand_word();
      default: return ovr_word;
    endcase
  endfunction

  // slips needed before the rotated pattern lines up again
  function automatic int slips_needed(input int ph);
    return (PAT_PERIOD - (ph % PAT_PERIOD)) % PAT_PERIOD;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic observe();
    logic [W-1:0] want;
    if (link.bitslip === 1'b1) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("slip_at", 64'(W'(rel())), 64'(want));
      check("slip_gap_ok", 64'((cyc - last_pulse) >= SLIP_PERIOD), 64'd1);
      last_pulse = cyc;
      phase = (phase + 1) % 64;
      n_pulses++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s);
    link.start = s;
    if (s) e0 = cyc + 1;
    link.raw_data = link_word();
  endtask

  task automatic tick_obs();
    @(negedge clk);
    observe();
  endtask

  task automatic tick(input logic s);
    tick_obs();
    drive(s);
  endtask

  task automatic run_to(input int r);
    while (rel() < r) tick(1'b0);
  endtask

  task automatic push_pulses(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(W'(1 + SLIP_PERIOD * i));
  endtask

  // start alignment with the link offset by ph bits and wait for lock
  task automatic start_and_lock(input string tag, input int ph);
    int n;
    int lock_at;
    phase = ph;
    data_mode = DM_LINK;
    n = slips_needed(ph);
    n_pulses = 0;
    exp_q.delete();
    push_pulses(n);
    lock_at = SLIP_PERIOD * n + LOCK_CNT;
    tick(1'b1);
    run_to(lock_at - 1);
    check({tag, "_locked_early"}, 64'(link.locked), 64'd0);
    tick(1'b0);
    check({tag, "_locked"}, 64'(link.locked), 64'd1);
    check({tag, "_fifo_ena"}, 64'(link.fifo_ena), 64'd1);
    check({tag, "_slip_count"}, 64'(link.slip_count), 64'(n));
    check({tag, "_pulses"}, 64'(n_pulses), 64'(n));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] t4_match;
    logic exp_locked;
    int err_run;
    int locked_cycles;
    logic [STATUS_W-1:0] exp_status;

    rst = 1'b1;
    link.start = 1'b0;
    link.train_mode = 1'b1;
    link.raw_data = '0;

    // reset state
    repeat (3) tick(1'b0);
    check("rst_bitslip", 64'(link.bitslip), 64'd0);
    check("rst_fifo_ena", 64'(link.fifo_ena), 64'd0);
    check("rst_locked", 64'(link.locked), 64'd0);
    check("rst_fail", 64'(link.fail), 64'd0);
    check("rst_slip_count", 64'(link.slip_count), 64'd0);
    check("rst_state", 64'(link.state_dbg), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick(1'b0);
    check("idle_state", 64'(link.state_dbg), 64'(ST_IDLE));

    // 1) already aligned: no slips, lock after LOCK_CNT matches
    start_and_lock("t1", 0);
    repeat (5) tick(1'b0);

    // 2) link rotated: 3 slips with full spacing, then lock
    start_and_lock("t2", 61);
    exp_status = STATUS_W'((3 << STAT_SLIP_LSB) + (1 << STAT_LOCKED_BIT) + (1 << STAT_FIFO_ENA_BIT));
    check("t2_status", 64'(link.link_status), 64'(exp_status));
    repeat (5) tick(1'b0);

    // 3) never aligns: MAX_SLIPS pulses then FAIL
    data_mode = DM_RAND;
    n_pulses = 0;
    exp_q.delete();
    push_pulses(MAX_SLIPS);
    tick(1'b1);
    run_to(SLIP_PERIOD * MAX_SLIPS);
    check("t3_fail_early", 64'(link.fail), 64'd0);
    tick(1'b0);
    check("t3_fail", 64'(link.fail), 64'd1);
    check("t3_fifo_ena", 64'(link.fifo_ena), 64'd0);
    check("t3_locked", 64'(link.locked), 64'd0);
    check("t3_slip_count", 64'(link.slip_count), 64'(MAX_SLIPS));
    check("t3_state", 64'(link.state_dbg), 64'(ST_FAIL));
    repeat (20) tick(1'b0);
    check("t3_pulses", 64'(n_pulses), 64'(MAX_SLIPS));
    check("t3_fail_held", 64'(link.fail), 64'd1);
    check("t3_pending", 64'(exp_q.size()), 64'd0);

    // 4) locked with training on: 3 errors, 1 match, 4 errors -> relock
    link.train_mode = 1'b1;
    start_and_lock("t4", 0);
    t4_match = 4'b1000;  // index 3 is the single good word
    exp_locked = 1'b1;
    err_run = 0;
    data_mode = DM_OVR;
    for (int k = 0; k < 8; k++) begin
      tick_obs();
      check("t4_locked_hold", 64'(link.locked), 64'(exp_locked));
      ovr_word = (k < 4 && t4_match[k]) ? PAT : rand_word();
      drive(1'b0);
      err_run = (ovr_word == PAT) ? 0 : err_run + 1;
      if (err_run == ERR_LIMIT) exp_locked = 1'b0;
    end
    tick_obs();
    check("t4_unlocked", 64'(link.locked), 64'd0);
    check("t4_fifo_ena", 64'(link.fifo_ena), 64'd0);
    check("t4_state", 64'(link.state_dbg), 64'(ST_CHECK));
    check("t4_slip_count", 64'(link.slip_count), 64'd0);
    data_mode = DM_LINK;
    phase = 0;
    drive(1'b0);
    repeat (LOCK_CNT + 4) tick(1'b0);
    check("t4_relocked", 64'(link.locked), 64'd1);

    // 5) locked with training off: payload never breaks lock
    link.train_mode = 1'b0;
    start_and_lock("t5", 0);
    data_mode = DM_RAND;
    locked_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0);
      if (link.locked === 1'b1 && link.fifo_ena === 1'b1) locked_cycles++;
    end
    check("t5_locked_cycles", 64'(locked_cycles), 64'd1000);
    check("t5_slip_count", 64'(link.slip_count), 64'd0);
    link.train_mode = 1'b1;

    // 6a) reset asserted during WAIT
    data_mode = DM_RAND;
    n_pulses = 0;
    exp_q.delete();
    push_pulses(1);
    tick(1'b1);
    run_to(3);
    check("t6_state_wait", 64'(link.state_dbg), 64'(ST_WAIT));
    check("t6_slips_before", 64'(link.slip_count), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_slip_count", 64'(link.slip_count), 64'd0);
    check("t6_rst_state", 64'(link.state_dbg), 64'(ST_IDLE));
    check("t6_rst_bitslip", 64'(link.bitslip), 64'd0);
    check("t6_rst_fifo_ena", 64'(link.fifo_ena), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) tick(1'b0);
    check("t6_idle_after_rst", 64'(link.state_dbg), 64'(ST_IDLE));
    check("t6_pending_a", 64'(exp_q.size()), 64'd0);

    // 6b) start asserted while the SLIP pulse is out
    exp_q.delete();
    push_pulses(1);
    tick(1'b1);
    tick(1'b0);
    tick_obs();
    check("t6_in_slip", 64'(link.bitslip), 64'd1);
    phase = 0;
    data_mode = DM_LINK;
    n_pulses = 0;
    drive(1'b1);
    run_to(1);
    check("t6_restart_bitslip", 64'(link.bitslip), 64'd0);
    check("t6_restart_slips", 64'(link.slip_count), 64'd0);
    check("t6_restart_state", 64'(link.state_dbg), 64'(ST_CHECK));
    run_to(LOCK_CNT);
    check("t6_locked", 64'(link.locked), 64'd1);
    repeat (10) tick(1'b0);
    check("t6_no_extra_pulse", 64'(n_pulses), 64'd0);
    check("t6_pending_b", 64'(exp_q.size()), 64'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
